// File: rtl/nested_loop_pkg.sv
// nested_loop_pkg: shared config-op encodings, FSM states and default widths
// for the nested-loop sequencer.
package nested_loop_pkg;
    localparam int DEF_NUM_MAX_LOOPS     = 7;
    localparam int DEF_LOG_NUM_MAX_LOOPS = 3;
    localparam int DEF_BASE_WIDTH        = 32;
    localparam int DEF_NUM_ITER_WIDTH    = 32;
    localparam int DEF_TIMEOUT_WIDTH     = 24;

    typedef enum logic [1:0] {
        CFG_BASE   = 2'b00,
        CFG_STRIDE = 2'b01,
        CFG_ITER   = 2'b10,
        CFG_LAUNCH = 2'b11
    } cfg_op_e;

    typedef enum logic [1:0] {IDLE, START, RUN} state_e;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/nested_loop_cfg_bank.sv
// nested_loop_cfg_bank: one loop-nest configuration bank (base, per-loop
// strides and iteration counts) with write decode and packed outputs.
module nested_loop_cfg_bank
    import nested_loop_pkg::*;
#(
    parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
    parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
    parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
    parameter int STRIDE_WIDTH      = BASE_WIDTH,
    parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
    parameter int DATA_WIDTH        = max3(BASE_WIDTH, STRIDE_WIDTH, NUM_ITER_WIDTH)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    we,
    input  cfg_op_e                                 op,
    input  logic [LOG_NUM_MAX_LOOPS-1:0]            idx,
    input  logic [DATA_WIDTH-1:0]                   data,
    output logic [BASE_WIDTH-1:0]                   base,
    output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride,
    output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter
);
    logic [NUM_MAX_LOOPS-1:0][STRIDE_WIDTH-1:0]   stride_q;
    logic [NUM_MAX_LOOPS-1:0][NUM_ITER_WIDTH-1:0] iter_q;
    logic hit;

    assign hit = int'(idx) < NUM_MAX_LOOPS;

    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            stride_q <= '0;
            iter_q   <= '0;
        end else if (we) begin
            if (op == CFG_BASE) base <= data[BASE_WIDTH-1:0];
            if (op == CFG_STRIDE && hit) stride_q[idx] <= data[STRIDE_WIDTH-1:0];
            if (op == CFG_ITER && hit) iter_q[idx] <= data[NUM_ITER_WIDTH-1:0];
        end
    end

    assign stride   = stride_q;
    assign num_iter = iter_q;
endmodule

// File: rtl/nested_loop_ctrl.sv
// nested_loop_ctrl: ping-pong config banks and launch/complete sequencing for
// one nested-loop address generator. Watchdog under NESTED_LOOP_CTRL_TIMEOUT_EN.
module nested_loop_ctrl
    import nested_loop_pkg::*;
#(
    parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
    parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
    parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
    parameter int STRIDE_WIDTH      = BASE_WIDTH,
    parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
    parameter int TIMEOUT_WIDTH     = DEF_TIMEOUT_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   cfg_valid,
    output logic                                                   cfg_ready,
    input  logic [1:0]                                             cfg_op,
    input  logic [LOG_NUM_MAX_LOOPS-1:0]                           cfg_loop_idx,
    input  logic [max3(BASE_WIDTH, STRIDE_WIDTH, NUM_ITER_WIDTH)-1:0] cfg_data,
    output logic [BASE_WIDTH-1:0]                                  gen_base,
    output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]                  gen_stride,
    output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0]                gen_num_iter,
    output logic                                                   gen_start,
    output logic                                                   gen_in_loop,
    input  logic                                                   gen_done,
    output logic                                                   busy,
    output logic                                                   nest_done,
    output logic                                                   err_cfg,
    output logic                                                   err_timeout
);
    localparam int DW = max3(BASE_WIDTH, STRIDE_WIDTH, NUM_ITER_WIDTH);

    state_e  state_q, state_d;
    cfg_op_e op;
    logic act_q, armed_q, gen_done_q, err_cfg_q;
    logic accept, wr, launch, swap, rise, timeout;
    logic [BASE_WIDTH-1:0]                   base0, base1;
    logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride0, stride1;
    logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] iter0, iter1;

    assign op          = cfg_op_e'(cfg_op);
    assign cfg_ready   = !armed_q;
    assign accept      = cfg_valid && cfg_ready;
    assign wr          = accept && op != CFG_LAUNCH;
    assign launch      = accept && op == CFG_LAUNCH;
    assign rise        = gen_done && !gen_done_q;
    assign gen_start   = state_q == START;
    assign gen_in_loop = state_q != IDLE;
    assign busy        = state_q != IDLE || armed_q;
    assign err_cfg     = err_cfg_q;

    // Writes always land in the bank that is not currently driving the generator.
    nested_loop_cfg_bank #(
        .NUM_MAX_LOOPS(NUM_MAX_LOOPS), .LOG_NUM_MAX_LOOPS(LOG_NUM_MAX_LOOPS),
        .BASE_WIDTH(BASE_WIDTH), .STRIDE_WIDTH(STRIDE_WIDTH),
        .NUM_ITER_WIDTH(NUM_ITER_WIDTH), .DATA_WIDTH(DW)
    ) u_bank0 (
        .clk(clk), .reset(reset), .we(wr && act_q), .op(op), .idx(cfg_loop_idx),
        .data(cfg_data), .base(base0), .stride(stride0), .num_iter(iter0)
    );

    nested_loop_cfg_bank #(
        .NUM_MAX_LOOPS(NUM_MAX_LOOPS), .LOG_NUM_MAX_LOOPS(LOG_NUM_MAX_LOOPS),
        .BASE_WIDTH(BASE_WIDTH), .STRIDE_WIDTH(STRIDE_WIDTH),
        .NUM_ITER_WIDTH(NUM_ITER_WIDTH), .DATA_WIDTH(DW)
    ) u_bank1 (
        .clk(clk), .reset(reset), .we(wr && !act_q), .op(op), .idx(cfg_loop_idx),
        .data(cfg_data), .base(base1), .stride(stride1), .num_iter(iter1)
    );

`ifdef NESTED_LOOP_CTRL_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd_q;
    logic err_timeout_q;
    assign timeout     = state_q == RUN && (&wd_q) && !rise;
    assign err_timeout = err_timeout_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= (state_q == START) ? '0 : (state_q == RUN && !(&wd_q)) ? wd_q + 1'b1 : wd_q;
            err_timeout_q <= err_timeout_q || timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        swap      = 1'b0;
        nest_done = 1'b0;
        case (state_q)
            IDLE: begin
                swap    = armed_q;
                state_d = armed_q ? START : IDLE;
            end
            START: state_d = RUN;
            RUN: begin
                nest_done = !reset && (rise || timeout);
                swap      = rise && armed_q;
                state_d   = rise ? (armed_q ? START : IDLE) : timeout ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            act_q        <= 1'b0;
            armed_q      <= 1'b0;
            gen_done_q   <= 1'b0;
            err_cfg_q    <= 1'b0;
            gen_base     <= '0;
            gen_stride   <= '0;
            gen_num_iter <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_q ^ swap;
            armed_q    <= swap ? 1'b0 : (armed_q || launch);
            gen_done_q <= gen_done;
            err_cfg_q  <= err_cfg_q || (wr && op != CFG_BASE && int'(cfg_loop_idx) >= NUM_MAX_LOOPS);
            if (swap) begin
                gen_base     <= act_q ? base0 : base1;
                gen_stride   <= act_q ? stride0 : stride1;
                gen_num_iter <= act_q ? iter0 : iter1;
            end
        end
    end
endmodule

// File: tb/tb_nested_loop_ctrl.sv
// tb_nested_loop_ctrl: directed + randomized checks of nested_loop_ctrl against
// a bank-level reference model. Timeout section runs under NESTED_LOOP_CTRL_TIMEOUT_EN.
module tb_nested_loop_ctrl;
    import nested_loop_pkg::*;

    localparam int N = 7;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset, cfg_valid, cfg_ready, gen_start, gen_in_loop, gen_done;
    logic busy, nest_done, err_cfg, err_timeout;
    logic [1:0] cfg_op;
    logic [2:0] cfg_loop_idx;
    logic [W-1:0] cfg_data, gen_base;
    logic [W*N-1:0] gen_stride, gen_num_iter;

    int checks = 0;
    int errors = 0;

    // Reference model: two banks, index of the bank that receives writes,
    // and the configuration the generator should see after the last launch.
    logic [W-1:0] mb[2];
    logic [W-1:0] ms[2][N];
    logic [W-1:0] mi[2][N];
    int sh;
    logic merr;
    logic [W-1:0] eb;
    logic [W*N-1:0] es, ei;

    nested_loop_ctrl #(.TIMEOUT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_op(cfg_op), .cfg_loop_idx(cfg_loop_idx), .cfg_data(cfg_data),
        .gen_base(gen_base), .gen_stride(gen_stride), .gen_num_iter(gen_num_iter),
        .gen_start(gen_start), .gen_in_loop(gen_in_loop), .gen_done(gen_done),
        .busy(busy), .nest_done(nest_done), .err_cfg(err_cfg), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pclk;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int b = 0; b < 2; b++) begin
            mb[b] = '0;
            for (int i = 0; i < N; i++) begin
                ms[b][i] = '0;
                mi[b][i] = '0;
            end
        end
        sh = 1;
        merr = 1'b0;
        eb = '0;
        es = '0;
        ei = '0;
    endtask

    task automatic do_cfg(input cfg_op_e op, input logic [2:0] idx, input logic [W-1:0] d);
        int w = 0;
        pclk;
        cfg_valid = 1'b1;
        cfg_op = op;
        cfg_loop_idx = idx;
        cfg_data = d;
        @(negedge clk);
        while (!cfg_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cfg_ready) chk("cfg_ready_wait", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (op == CFG_BASE) mb[sh] = d;
        else if (op == CFG_STRIDE) begin
            if (idx < N) ms[sh][idx] = d;
            else merr = 1'b1;
        end else if (op == CFG_ITER) begin
            if (idx < N) mi[sh][idx] = d;
            else merr = 1'b1;
        end else begin
            eb = mb[sh];
            for (int i = 0; i < N; i++) begin
                es[i*W +: W] = ms[sh][i];
                ei[i*W +: W] = mi[sh][i];
            end
            sh ^= 1;
        end
    endtask

    task automatic rand_writes(input int n);
        for (int k = 0; k < n; k++) begin
            int op = $urandom_range(0, 2);
            logic [W-1:0] d = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            do_cfg(cfg_op_e'(op[1:0]), 3'($urandom_range(0, 7)), d);
        end
    endtask

    // LAUNCH with the FSM idle; returns at the negedge of the START cycle.
    task automatic launch_and_check(input string t);
        do_cfg(CFG_LAUNCH, 3'd0, '0);
        @(negedge clk);
        chk({t, "_ready_lo"}, cfg_ready, 0);
        chk({t, "_busy"}, busy, 1);
        chk({t, "_start_early"}, gen_start, 0);
        pclk;
        @(negedge clk);
        chk({t, "_start"}, gen_start, 1);
        chk({t, "_in_loop"}, gen_in_loop, 1);
        chk({t, "_base"}, gen_base, eb);
        chk({t, "_stride"}, gen_stride, es);
        chk({t, "_iter"}, gen_num_iter, ei);
    endtask

    // From START: stay n extra RUN cycles, raise gen_done, expect one nest_done.
    task automatic finish_nest(input string t, input int n);
        pclk;
        @(negedge clk);
        chk({t, "_start_once"}, gen_start, 0);
        chk({t, "_run"}, gen_in_loop, 1);
        repeat (n) pclk;
        pclk;
        gen_done = 1'b1;
        @(negedge clk);
        chk({t, "_nest_done"}, nest_done, 1);
        pclk;
        gen_done = 1'b0;
        @(negedge clk);
        chk({t, "_nest_done_pulse"}, nest_done, 0);
        chk({t, "_idle"}, gen_in_loop, 0);
        chk({t, "_not_busy"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0] a_base;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_op = '0;
        cfg_loop_idx = '0;
        cfg_data = '0;
        gen_done = 1'b0;
        model_reset();
        repeat (3) pclk;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_start", gen_start, 0);
        chk("rst_in_loop", gen_in_loop, 0);
        chk("rst_nest_done", nest_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cfg", err_cfg, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_base", gen_base, 0);
        chk("rst_stride", gen_stride, 0);
        chk("rst_iter", gen_num_iter, 0);

        // Basic nest
        do_cfg(CFG_BASE, 3'd0, 32'h100);
        do_cfg(CFG_STRIDE, 3'd0, 32'd4);
        do_cfg(CFG_ITER, 3'd0, 32'd3);
        launch_and_check("basic");
        chk("basic_base_const", gen_base, 32'h100);
        chk("basic_iter0_const", gen_num_iter[W-1:0], 32'd3);
        chk("basic_stride0_const", gen_stride[W-1:0], 32'd4);
        finish_nest("basic", 2);

        // gen_done edge in IDLE is ignored
        pclk;
        gen_done = 1'b1;
        @(negedge clk);
        chk("idle_done_ignored", nest_done, 0);
        pclk;
        gen_done = 1'b0;
        @(negedge clk);
        chk("idle_stays", gen_in_loop, 0);

        // Back-to-back nests with gen_done held across the hand-over
        rand_writes(4);
        launch_and_check("nestA");
        a_base = eb;
        rand_writes(2);
        do_cfg(CFG_BASE, 3'd0, 32'hB0B0_0000 ^ W'($urandom_range(0, 255)));
        do_cfg(CFG_LAUNCH, 3'd0, '0);
        @(negedge clk);
        chk("b2b_ready_lo", cfg_ready, 0);
        chk("b2b_base_still_A", gen_base, a_base);
        repeat (3) begin
            pclk;
            @(negedge clk);
            chk("b2b_stall", cfg_ready, 0);
            chk("b2b_no_done", nest_done, 0);
        end
        pclk;
        gen_done = 1'b1;
        @(negedge clk);
        chk("b2b_A_done", nest_done, 1);
        chk("b2b_A_no_start", gen_start, 0);
        pclk;
        @(negedge clk);
        chk("b2b_B_start", gen_start, 1);
        chk("b2b_B_done_lo", nest_done, 0);
        chk("b2b_B_base", gen_base, eb);
        chk("b2b_B_stride", gen_stride, es);
        chk("b2b_B_iter", gen_num_iter, ei);
        chk("b2b_ready_hi", cfg_ready, 1);
        repeat (3) begin
            pclk;
            @(negedge clk);
            chk("held_done_no_complete", nest_done, 0);
            chk("held_done_in_loop", gen_in_loop, 1);
        end
        pclk;
        gen_done = 1'b0;
        @(negedge clk);
        chk("held_fall_no_done", nest_done, 0);
        pclk;
        gen_done = 1'b1;
        @(negedge clk);
        chk("held_rise_done", nest_done, 1);
        pclk;
        gen_done = 1'b0;
        @(negedge clk);
        chk("b2b_idle", gen_in_loop, 0);

        // Out-of-range loop index
        do_cfg(CFG_STRIDE, 3'd7, W'($urandom));
        @(negedge clk);
        chk("err_cfg_set", err_cfg, 1);
        do_cfg(CFG_ITER, 3'd7, W'($urandom));
        launch_and_check("errcfg");
        finish_nest("errcfg", 1);
        chk("err_cfg_sticky", err_cfg, 1);

        // Randomized nests
        for (int n = 0; n < 15; n++) begin
            rand_writes($urandom_range(0, 6));
            launch_and_check("rand");
            finish_nest("rand", $urandom_range(0, 5));
            chk("rand_err_cfg", err_cfg, merr);
            chk("rand_err_timeout", err_timeout, 0);
        end

`ifdef NESTED_LOOP_CTRL_TIMEOUT_EN
        begin
            int cnt = 0;
            launch_and_check("wd");
            pclk;
            @(negedge clk);
            while (!nest_done && cnt < 40) begin
                cnt++;
                pclk;
                @(negedge clk);
            end
            chk("wd_cycles", cnt, 15);
            chk("wd_err_same_cycle", err_timeout, 0);
            pclk;
            @(negedge clk);
            chk("wd_err_timeout", err_timeout, 1);
            chk("wd_idle", gen_in_loop, 0);
        end
`endif

        // Reset in the middle of RUN
        rand_writes(3);
        launch_and_check("rstrun");
        pclk;
        pclk;
        reset = 1'b1;
        gen_done = 1'b1;
        @(negedge clk);
        chk("rstrun_no_done", nest_done, 0);
        pclk;
        reset = 1'b0;
        gen_done = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rstrun_in_loop", gen_in_loop, 0);
        chk("rstrun_start", gen_start, 0);
        chk("rstrun_nest_done", nest_done, 0);
        chk("rstrun_ready", cfg_ready, 1);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_err_cfg", err_cfg, 0);
        chk("rstrun_err_timeout", err_timeout, 0);
        chk("rstrun_base", gen_base, 0);
        chk("rstrun_stride", gen_stride, 0);
        chk("rstrun_iter", gen_num_iter, 0);

        // Fresh nest after reset
        do_cfg(CFG_BASE, 3'd0, W'($urandom));
        do_cfg(CFG_ITER, 3'd6, W'($urandom));
        launch_and_check("post_rst");
        finish_nest("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
